// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU controller: opcodes, FSM states, ALU select codes
// and instruction field positions.
package alu_ctrl_pkg;

    localparam int DATA_W  = 8;
    localparam int PC_W    = 8;
    localparam int INSTR_W = 16;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_XOR  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SHL  = 3'b011;
    localparam logic [2:0] OP_LDI  = 3'b100;
    localparam logic [2:0] OP_JZ   = 3'b101;
    localparam logic [2:0] OP_JC   = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    localparam logic [1:0] SEL_AND = 2'b00;
    localparam logic [1:0] SEL_XOR = 2'b01;
    localparam logic [1:0] SEL_ADD = 2'b10;
    localparam logic [1:0] SEL_SHL = 2'b11;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 13;
    localparam int RD_MSB  = 12;
    localparam int RD_LSB  = 11;
    localparam int RS_MSB  = 10;
    localparam int RS_LSB  = 9;
    localparam int NC_BIT  = 8;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_HALTED    = 3'd5
    } state_t;

    function automatic logic is_alu_op(input logic [2:0] op);
        return (op[2] == 1'b0);
    endfunction

    function automatic logic [1:0] op_to_sel(input logic [2:0] op);
        logic [1:0] sel;
        case (op)
            OP_AND:  sel = SEL_AND;
            OP_XOR:  sel = SEL_XOR;
            OP_ADD:  sel = SEL_ADD;
            default: sel = SEL_SHL;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/reg_file_4x8.sv
// Four 8-bit registers: two asynchronous read ports, one synchronous write port,
// synchronous active-low clear.
module reg_file_4x8
    import alu_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n_i,
    input  logic              we_i,
    input  logic [1:0]        waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [1:0]        raddr_a_i,
    output logic [DATA_W-1:0] rdata_a_o,
    input  logic [1:0]        raddr_b_i,
    output logic [DATA_W-1:0] rdata_b_o
);

    logic [DATA_W-1:0] regs_q [4];

    always_ff @(posedge clk) begin
        if (!rst_n_i) begin
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = regs_q[raddr_a_i];
    assign rdata_b_o = regs_q[raddr_b_i];

endmodule

// File: rtl/alu_control_unit.sv
// Multi-cycle controller for the 8-bit ALU: fetch, decode, execute, writeback
// with a 4x8 register file, 8-bit PC and latched carry/zero flags.
module alu_control_unit
    import alu_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    output logic [1:0]         alu_sel,
    input  logic [DATA_W-1:0]  alu_out,
    input  logic               alu_co,
    input  logic               alu_z,
    output logic               flag_co,
    output logic               flag_z,
    output logic               busy,
    output logic               halted
);

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [PC_W-1:0]   imem_addr_q, imem_addr_d;
    logic [2:0]        op_q, op_d;
    logic [1:0]        rd_q, rd_d;
    logic [7:0]        imm_q, imm_d;
    logic [DATA_W-1:0] temp_q, temp_d;
    logic              tco_q, tco_d;
    logic              tz_q, tz_d;
    logic              flag_co_q, flag_co_d;
    logic              flag_z_q, flag_z_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic [1:0]        alu_sel_q, alu_sel_d;

    logic [2:0]        dec_op;
    logic [1:0]        dec_rd, dec_rs;
    logic              rf_we;
    logic [DATA_W-1:0] rf_wdata;
    logic [DATA_W-1:0] rf_rdata_a, rf_rdata_b;
    logic [PC_W-1:0]   next_pc;
    logic              unused_nc_bit;

    assign dec_op        = imem_data[OP_MSB:OP_LSB];
    assign dec_rd        = imem_data[RD_MSB:RD_LSB];
    assign dec_rs        = imem_data[RS_MSB:RS_LSB];
    assign unused_nc_bit = imem_data[NC_BIT];

    // Operands are read straight from the ROM word in DECODE so they are already
    // registered on the ALU inputs for the whole EXECUTE cycle.
    reg_file_4x8 u_rf (
        .clk       (clk),
        .rst_n_i   (rst_n),
        .we_i      (rf_we),
        .waddr_i   (rd_q),
        .wdata_i   (rf_wdata),
        .raddr_a_i (dec_rd),
        .rdata_a_o (rf_rdata_a),
        .raddr_b_i (dec_rs),
        .rdata_b_o (rf_rdata_b)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pc_q        <= '0;
            imem_addr_q <= '0;
            op_q        <= '0;
            rd_q        <= '0;
            imm_q       <= '0;
            temp_q      <= '0;
            tco_q       <= 1'b0;
            tz_q        <= 1'b0;
            flag_co_q   <= 1'b0;
            flag_z_q    <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            imem_addr_q <= imem_addr_d;
            op_q        <= op_d;
            rd_q        <= rd_d;
            imm_q       <= imm_d;
            temp_q      <= temp_d;
            tco_q       <= tco_d;
            tz_q        <= tz_d;
            flag_co_q   <= flag_co_d;
            flag_z_q    <= flag_z_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_sel_q   <= alu_sel_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        imem_addr_d = imem_addr_q;
        op_d        = op_q;
        rd_d        = rd_q;
        imm_d       = imm_q;
        temp_d      = temp_q;
        tco_d       = tco_q;
        tz_d        = tz_q;
        flag_co_d   = flag_co_q;
        flag_z_d    = flag_z_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_sel_d   = alu_sel_q;
        rf_we       = 1'b0;
        rf_wdata    = temp_q;
        next_pc     = pc_q + PC_W'(1);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_FETCH;
                    imem_addr_d = pc_q;
                end
            end
            ST_FETCH: begin
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                op_d  = dec_op;
                rd_d  = dec_rd;
                imm_d = imem_data[IMM_MSB:IMM_LSB];
                if (dec_op == OP_HALT) begin
                    state_d = ST_HALTED;
                end else begin
                    state_d = ST_EXECUTE;
                end
                if (is_alu_op(dec_op)) begin
                    alu_a_d   = rf_rdata_a;
                    alu_b_d   = rf_rdata_b;
                    alu_sel_d = op_to_sel(dec_op);
                end
            end
            ST_EXECUTE: begin
                state_d = ST_WRITEBACK;
                if (is_alu_op(op_q)) begin
                    temp_d = alu_out;
                    tco_d  = alu_co;
                    tz_d   = alu_z;
                end
            end
            ST_WRITEBACK: begin
                state_d = ST_FETCH;
                if (is_alu_op(op_q)) begin
                    rf_we     = 1'b1;
                    rf_wdata  = temp_q;
                    flag_co_d = tco_q;
                    flag_z_d  = tz_q;
                end else if (op_q == OP_LDI) begin
                    rf_we    = 1'b1;
                    rf_wdata = imm_q;
                end else if (op_q == OP_JZ && flag_z_q) begin
                    next_pc = imm_q;
                end else if (op_q == OP_JC && flag_co_q) begin
                    next_pc = imm_q;
                end
                pc_d        = next_pc;
                imem_addr_d = next_pc;
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign imem_addr = imem_addr_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_sel   = alu_sel_q;
    assign flag_co   = flag_co_q;
    assign flag_z    = flag_z_q;
    assign busy      = (state_q == ST_FETCH) || (state_q == ST_DECODE) ||
                       (state_q == ST_EXECUTE) || (state_q == ST_WRITEBACK);
    assign halted    = (state_q == ST_HALTED);

endmodule

// File: tb/tb_alu_control_unit.sv
// Directed bench for alu_control_unit: small programs in a tb ROM, a behavioural ALU,
// expectations queued by the stimulus and compared by a negedge monitor.
module tb_alu_control_unit;
    import alu_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  imem_addr;
    logic [15:0] imem_data;
    logic [7:0]  alu_a, alu_b, alu_out;
    logic [1:0]  alu_sel;
    logic        alu_co, alu_z;
    logic        flag_co, flag_z, busy, halted;

    logic [15:0] rom [256];

    localparam int F_R0 = 0, F_R1 = 1, F_R2 = 2, F_R3 = 3, F_CO = 4, F_Z = 5;
    localparam int F_PC = 6, F_BUSY = 7, F_HALT = 8, F_IMEM = 9, F_SEL = 10, F_A = 11;

    localparam int TIMEOUT_CYCLES = 2000;

    typedef struct {
        int         fld;
        logic [7:0] exp;
        string      name;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       mon_e;
    logic [7:0] mon_act;
    logic       chk_req = 1'b0;
    logic       test_done = 1'b0;
    int         n_checks = 0;
    int         n_fail = 0;

    alu_control_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .imem_addr (imem_addr),
        .imem_data (imem_data),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sel   (alu_sel),
        .alu_out   (alu_out),
        .alu_co    (alu_co),
        .alu_z     (alu_z),
        .flag_co   (flag_co),
        .flag_z    (flag_z),
        .busy      (busy),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    always @(posedge clk) imem_data <= rom[imem_addr];

    // Behavioural 8-bit ALU
    logic [8:0] sum9;
    always_comb begin
        sum9    = {1'b0, alu_a} + {1'b0, alu_b};
        alu_out = 8'h00;
        alu_co  = 1'b0;
        case (alu_sel)
            2'b00: alu_out = alu_a & alu_b;
            2'b01: alu_out = alu_a ^ alu_b;
            2'b10: begin alu_out = sum9[7:0]; alu_co = sum9[8]; end
            default: begin alu_out = {alu_a[6:0], alu_a[7]}; alu_co = alu_a[7]; end
        endcase
        alu_z = (alu_out == 8'h00);
    end

    function automatic logic [7:0] actual(input int f);
        case (f)
            F_R0:    return dut.u_rf.regs_q[0];
            F_R1:    return dut.u_rf.regs_q[1];
            F_R2:    return dut.u_rf.regs_q[2];
            F_R3:    return dut.u_rf.regs_q[3];
            F_CO:    return {7'b0, flag_co};
            F_Z:     return {7'b0, flag_z};
            F_PC:    return dut.pc_q;
            F_BUSY:  return {7'b0, busy};
            F_HALT:  return {7'b0, halted};
            F_IMEM:  return imem_addr;
            F_SEL:   return {6'b0, alu_sel};
            default: return alu_a;
        endcase
    endfunction

    always @(negedge clk) begin
        if (chk_req) begin
            while (sb_q.size() > 0) begin
                mon_e   = sb_q.pop_front();
                mon_act = actual(mon_e.fld);
                n_checks++;
                if (mon_act !== mon_e.exp) begin
                    n_fail++;
                    $display("FAIL %s: got 0x%02h, expected 0x%02h", mon_e.name, mon_act, mon_e.exp);
                end else begin
                    $display("ok   %s: 0x%02h", mon_e.name, mon_act);
                end
            end
        end
    end

    initial begin
        repeat (TIMEOUT_CYCLES) @(posedge clk);
        if (!test_done) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: test not finished after %0d cycles", TIMEOUT_CYCLES);
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
            $finish;
        end
    end

    function automatic logic [15:0] mk(input logic [2:0] op, input logic [1:0] rd,
                                       input logic [1:0] rs, input logic [7:0] imm);
        return {op, rd, rs, 1'b0, imm};
    endfunction

    task automatic expect_val(input int f, input logic [7:0] v, input string n);
        exp_t e;
        e.fld  = f;
        e.exp  = v;
        e.name = n;
        sb_q.push_back(e);
    endtask

    task automatic check_now();
        chk_req = 1'b1;
        @(negedge clk);
        #1 chk_req = 1'b0;
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = mk(OP_HALT, 2'd0, 2'd0, 8'h00);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic go();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        clear_rom();
        do_reset();

        n_checks++;
        if (busy !== 1'b0 || halted !== 1'b0 || dut.pc_q !== 8'h00 || imem_addr !== 8'h00 ||
            alu_a !== 8'h00 || alu_b !== 8'h00 || alu_sel !== 2'b00 ||
            flag_co !== 1'b0 || flag_z !== 1'b0 ||
            dut.u_rf.regs_q[0] !== 8'h00 || dut.u_rf.regs_q[1] !== 8'h00 ||
            dut.u_rf.regs_q[2] !== 8'h00 || dut.u_rf.regs_q[3] !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b halted=%b pc=0x%02h imem=0x%02h a=0x%02h b=0x%02h sel=%b co=%b z=%b",
                     busy, halted, dut.pc_q, imem_addr, alu_a, alu_b, alu_sel, flag_co, flag_z);
        end else begin
            $display("ok   reset_state: all outputs and registers zero");
        end

        // Reset during EXECUTE of ADD
        rom[0] = mk(OP_LDI, 2'd1, 2'd0, 8'h05);
        rom[1] = mk(OP_ADD, 2'd1, 2'd1, 8'h00);
        go();
        edges(6);
        expect_val(F_SEL, 8'h02, "rst_pre_sel_add");
        expect_val(F_A, 8'h05, "rst_pre_alu_a");
        check_now();
        rst_n = 1'b0;
        edges(1);
        expect_val(F_BUSY, 8'h00, "rst_busy");
        expect_val(F_HALT, 8'h00, "rst_halted");
        expect_val(F_PC, 8'h00, "rst_pc");
        expect_val(F_R0, 8'h00, "rst_r0");
        expect_val(F_R1, 8'h00, "rst_r1");
        expect_val(F_R2, 8'h00, "rst_r2");
        expect_val(F_R3, 8'h00, "rst_r3");
        expect_val(F_CO, 8'h00, "rst_co");
        expect_val(F_Z, 8'h00, "rst_z");
        expect_val(F_SEL, 8'h00, "rst_sel");
        check_now();
        rst_n = 1'b1;

        // ADD with carry-out and zero result
        clear_rom();
        do_reset();
        rom[0] = mk(OP_LDI, 2'd1, 2'd0, 8'h0F);
        rom[1] = mk(OP_LDI, 2'd2, 2'd0, 8'hF1);
        rom[2] = mk(OP_ADD, 2'd1, 2'd2, 8'h00);
        go();
        edges(11);
        expect_val(F_R1, 8'h0F, "add_r1_before_wb");
        check_now();
        edges(1);
        expect_val(F_R1, 8'h00, "add_r1");
        expect_val(F_R2, 8'hF1, "add_r2");
        expect_val(F_CO, 8'h01, "add_co");
        expect_val(F_Z, 8'h01, "add_z");
        expect_val(F_PC, 8'h03, "add_pc");
        check_now();

        // Circular shift left
        clear_rom();
        do_reset();
        rom[0] = mk(OP_LDI, 2'd0, 2'd0, 8'h81);
        rom[1] = mk(OP_SHL, 2'd0, 2'd0, 8'h00);
        go();
        edges(6);
        expect_val(F_SEL, 8'h03, "shl_sel_exec");
        expect_val(F_A, 8'h81, "shl_alu_a");
        check_now();
        edges(2);
        expect_val(F_R0, 8'h03, "shl_r0");
        expect_val(F_CO, 8'h01, "shl_co");
        expect_val(F_Z, 8'h00, "shl_z");
        check_now();

        // JZ taken after XOR R3,R3
        clear_rom();
        do_reset();
        rom[0]     = mk(OP_LDI, 2'd3, 2'd0, 8'hAA);
        rom[1]     = mk(OP_XOR, 2'd3, 2'd3, 8'h00);
        rom[2]     = mk(OP_JZ,  2'd0, 2'd0, 8'h10);
        go();
        edges(12);
        expect_val(F_PC, 8'h10, "jz_taken_pc");
        expect_val(F_IMEM, 8'h10, "jz_taken_imem");
        expect_val(F_R3, 8'h00, "jz_xor_r3");
        expect_val(F_Z, 8'h01, "jz_xor_z");
        check_now();

        // JZ not taken after nonzero XOR
        clear_rom();
        do_reset();
        rom[0] = mk(OP_LDI, 2'd3, 2'd0, 8'hAA);
        rom[1] = mk(OP_LDI, 2'd2, 2'd0, 8'h55);
        rom[2] = mk(OP_XOR, 2'd3, 2'd2, 8'h00);
        rom[3] = mk(OP_JZ,  2'd0, 2'd0, 8'h10);
        go();
        edges(16);
        expect_val(F_PC, 8'h04, "jz_nt_pc");
        expect_val(F_R3, 8'hFF, "jz_nt_r3");
        expect_val(F_Z, 8'h00, "jz_nt_z");
        check_now();

        // HALT at 0x05, then start pulses are ignored
        clear_rom();
        do_reset();
        for (int i = 0; i < 5; i++) rom[i] = mk(OP_LDI, 2'd0, 2'd0, 8'(i + 1));
        go();
        edges(21);
        expect_val(F_BUSY, 8'h01, "halt_busy_decode");
        expect_val(F_HALT, 8'h00, "halt_not_yet");
        check_now();
        edges(1);
        expect_val(F_HALT, 8'h01, "halt_halted");
        expect_val(F_BUSY, 8'h00, "halt_busy");
        expect_val(F_PC, 8'h05, "halt_pc");
        expect_val(F_R0, 8'h05, "halt_r0");
        check_now();
        go();
        edges(3);
        expect_val(F_HALT, 8'h01, "halt_start_halted");
        expect_val(F_BUSY, 8'h00, "halt_start_busy");
        expect_val(F_PC, 8'h05, "halt_start_pc");
        check_now();

        // JC to 0xFF, LDI there, PC wraps to 0x00
        clear_rom();
        do_reset();
        rom[0]     = mk(OP_LDI, 2'd0, 2'd0, 8'h80);
        rom[1]     = mk(OP_ADD, 2'd0, 2'd0, 8'h00);
        rom[2]     = mk(OP_JC,  2'd0, 2'd0, 8'hFF);
        rom[8'hFF] = mk(OP_LDI, 2'd1, 2'd0, 8'h77);
        go();
        edges(12);
        expect_val(F_PC, 8'hFF, "jc_pc");
        expect_val(F_IMEM, 8'hFF, "jc_imem");
        expect_val(F_CO, 8'h01, "jc_co");
        check_now();
        edges(4);
        expect_val(F_PC, 8'h00, "wrap_pc");
        expect_val(F_IMEM, 8'h00, "wrap_imem");
        expect_val(F_R1, 8'h77, "wrap_r1");
        expect_val(F_CO, 8'h01, "wrap_co");
        expect_val(F_Z, 8'h01, "wrap_z");
        check_now();

        test_done = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
